// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard sequencer for the 5-stage pipeline
// Drives stage enables/flushes, registered EX forwarding selects and stall/flush event counters.
module pipeline_hazard_ctrl #(
   parameter int RIW     = 4,
   parameter int CW      = 16,
   parameter int DRAIN   = 3,
   parameter int R0_ZERO = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [RIW-1:0] d_Ra,
   input  logic [RIW-1:0] d_Rb,
   input  logic [RIW-1:0] d_Rc,
   input  logic           d_useA,
   input  logic           d_useB,
   input  logic           d_useC,
   input  logic [RIW-1:0] e_Rc,
   input  logic           e_regWrite,
   input  logic           e_memToReg,
   input  logic [RIW-1:0] m_Rc,
   input  logic           m_regWrite,
   input  logic           e_branchTaken,
   input  logic           mem_req,
   input  logic           mem_ready,
   input  logic           halt_req,
   output logic           en_pc,
   output logic           en_ifid,
   output logic           en_idex,
   output logic           en_exmem,
   output logic           en_memwb,
   output logic           flush_ifid,
   output logic           flush_idex,
   output logic [1:0]     fwdA,
   output logic [1:0]     fwdB,
   output logic [1:0]     fwdC,
   output logic [CW-1:0]  stall_cnt,
   output logic [CW-1:0]  flush_cnt,
   output logic           halted
);

   typedef enum logic [2:0] {
      S_RUN,
      S_LDSTALL,
      S_MEMWAIT,
      S_DRAIN,
      S_HALT
   } state_t;

   localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN - 1);

   state_t         state, state_d;
   logic [DW-1:0]  drain_cnt, drain_d;
   logic           stall_inc, flush_inc;
   logic           memwait, load_use;
   logic [1:0]     fwdA_d, fwdB_d, fwdC_d;

   function automatic logic hit(input logic [RIW-1:0] src, input logic use_bit,
                                input logic [RIW-1:0] dst, input logic wr);
      hit = use_bit && wr && (src == dst) && !((R0_ZERO != 0) && (src == '0));
   endfunction

   // A load in EX cannot supply its result yet, so it only ever forwards from MEM.
   function automatic logic [1:0] fwd_sel(input logic [RIW-1:0] src, input logic use_bit,
                                          input logic [RIW-1:0] erc, input logic ewr,
                                          input logic eld, input logic [RIW-1:0] mrc,
                                          input logic mwr);
      if (hit(src, use_bit, erc, ewr) && !eld)
         fwd_sel = 2'b01;
      else if (hit(src, use_bit, mrc, mwr))
         fwd_sel = 2'b10;
      else
         fwd_sel = 2'b00;
   endfunction

   assign memwait  = mem_req & ~mem_ready;
   assign load_use = e_regWrite & e_memToReg &
                     (hit(d_Ra, d_useA, e_Rc, 1'b1) |
                      hit(d_Rb, d_useB, e_Rc, 1'b1) |
                      hit(d_Rc, d_useC, e_Rc, 1'b1));

   assign fwdA_d = fwd_sel(d_Ra, d_useA, e_Rc, e_regWrite, e_memToReg, m_Rc, m_regWrite);
   assign fwdB_d = fwd_sel(d_Rb, d_useB, e_Rc, e_regWrite, e_memToReg, m_Rc, m_regWrite);
   assign fwdC_d = fwd_sel(d_Rc, d_useC, e_Rc, e_regWrite, e_memToReg, m_Rc, m_regWrite);

   assign halted = (state == S_HALT);

   always_comb begin
      en_pc      = 1'b1;
      en_ifid    = 1'b1;
      en_idex    = 1'b1;
      en_exmem   = 1'b1;
      en_memwb   = 1'b1;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      state_d    = state;
      drain_d    = drain_cnt;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;

      if (rst) begin
         {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
         state_d    = S_RUN;
      end else begin
         case (state)
            S_RUN: begin
               if (memwait) begin
                  {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
                  state_d = S_MEMWAIT;
               end else if (e_branchTaken) begin
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
                  flush_inc  = 1'b1;
               end else if (load_use) begin
                  en_pc      = 1'b0;
                  en_ifid    = 1'b0;
                  flush_idex = 1'b1;
                  stall_inc  = 1'b1;
                  state_d    = S_LDSTALL;
               // A pending load-use is resolved first so the drained ID instruction sees correct data.
               end else if (halt_req) begin
                  en_pc      = 1'b0;
                  flush_ifid = 1'b1;
                  drain_d    = DRAIN_INIT;
                  state_d    = S_DRAIN;
               end
            end
            S_LDSTALL: begin
               if (memwait) begin
                  {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
                  state_d = S_MEMWAIT;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_MEMWAIT: begin
               if (mem_ready)
                  state_d = S_RUN;
               else
                  {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
            end
            S_DRAIN: begin
               en_pc = 1'b0;
               if (memwait) begin
                  {en_ifid, en_idex, en_exmem, en_memwb} = 4'b0000;
               end else begin
                  flush_ifid = 1'b1;
                  if (drain_cnt == '0)
                     state_d = S_HALT;
                  else
                     drain_d = drain_cnt - 1'b1;
               end
            end
            S_HALT: begin
               {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         drain_cnt <= '0;
         fwdA      <= 2'b00;
         fwdB      <= 2'b00;
         fwdC      <= 2'b00;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_d;
         drain_cnt <= drain_d;
         if (stall_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
         if (en_idex) begin
            if (flush_idex) begin
               fwdA <= 2'b00;
               fwdB <= 2'b00;
               fwdC <= 2'b00;
            end else begin
               fwdA <= fwdA_d;
               fwdB <= fwdB_d;
               fwdC <= fwdC_d;
            end
         end
      end
   end

endmodule
